// File: rtl/regfile_arbiter.sv
// Register-file port arbiter: a 2-entry writeback buffer shares the single
// register-file port with operand reads, plus a flush/drain handshake.
module regfile_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        rd_req,
    input  logic [4:0]  rd_left_addr,
    input  logic [4:0]  rd_right_addr,
    output logic        rd_gnt,
    output logic        rd_valid,
    output logic [31:0] rd_left_data,
    output logic [31:0] rd_right_data,
    input  logic        flush,
    output logic        flush_done,
    output logic        rf_we,
    output logic [4:0]  rf_dest_addr,
    output logic [31:0] rf_result,
    output logic [4:0]  rf_left_addr,
    output logic [4:0]  rf_right_addr,
    input  logic [31:0] rf_left_out,
    input  logic [31:0] rf_right_out
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StFlush = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [4:0]  addr_q [2];
    logic [4:0]  addr_d [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [4:0]  left_q, left_d;
    logic [4:0]  right_q, right_d;
    logic        rd_valid_q, rd_valid_d;

    logic        push, pop, read_sel, hazard, tail;
    logic [1:0]  entry_vld;

    assign wb_ready = (count_q != 2'd2);
    assign push     = wb_valid && wb_ready;
    assign tail     = head_q ^ count_q[0];

    always_comb begin
        entry_vld[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !head_q);
        entry_vld[1] = (count_q == 2'd2) || ((count_q == 2'd1) && head_q);
        hazard = (entry_vld[0] && (addr_q[0] == rd_left_addr || addr_q[0] == rd_right_addr))
              || (entry_vld[1] && (addr_q[1] == rd_left_addr || addr_q[1] == rd_right_addr));
    end

    // One register-file access per cycle; read grant is masked in reset so the
    // port is quiet while rst_n is low even with rd_req held.
    always_comb begin
        pop      = 1'b0;
        read_sel = 1'b0;
        if (state_q != StRun) begin
            pop = (count_q != 2'd0);
        end else if (rd_req && hazard) begin
            pop = 1'b1;
        end else if (count_q == 2'd2) begin
            pop = 1'b1;
        end else if (rd_req) begin
            read_sel = rst_n;
        end else begin
            pop = (count_q != 2'd0);
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        head_d  = head_q ^ pop;
        addr_d  = addr_q;
        data_d  = data_q;
        if (push) begin
            addr_d[tail] = wb_addr;
            data_d[tail] = wb_data;
        end
        left_d     = read_sel ? rd_left_addr : left_q;
        right_d    = read_sel ? rd_right_addr : right_q;
        rd_valid_d = read_sel;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (flush) state_d = StFlush;
            StFlush: if (count_q == 2'd0 && !push) state_d = StDone;
            StDone:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            left_q     <= 5'd0;
            right_q    <= 5'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            left_q     <= left_d;
            right_q    <= right_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Buffer payload needs no reset: entries are only observed when counted valid.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign rd_gnt        = read_sel;
    assign rd_valid      = rd_valid_q;
    assign rd_left_data  = rf_left_out;
    assign rd_right_data = rf_right_out;
    assign flush_done    = (state_q == StDone);
    assign rf_we         = pop;
    assign rf_dest_addr  = addr_q[head_q];
    assign rf_result     = data_q[head_q];
    assign rf_left_addr  = left_d;
    assign rf_right_addr = right_d;

endmodule
